// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite register-file responder.
// Holds the default widths, the response codes and the state types for the
// write and read handshake FSMs. It has no ports.
package axi_lite_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_RESP_WIDTH = 3;
  localparam int DEF_NUM_REGS   = 8;

  localparam logic [DEF_RESP_WIDTH-1:0] RESP_OKAY   = 3'd0;
  localparam logic [DEF_RESP_WIDTH-1:0] RESP_SLVERR = 3'd2;

  // state    | meaning
  // WR_IDLE  | collecting AW and W, in either order
  // WR_RESP  | write committed, bvalid held until bready
  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  // state    | meaning
  // RD_IDLE  | arready asserted, waiting for a read address
  // RD_DATA  | rdata/rresp held with rvalid until rready
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  // Number of byte-address bits below the word index.
  function automatic int word_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_lite_regfile_slave_if.sv
// AXI-Lite bus bundle between one bus master port and the register-file
// responder. Clock and reset are not part of the bundle.
//   slave modport : inputs awaddr/awvalid, wdata/wstrb/wvalid, bready,
//                   araddr/arvalid, rready; outputs the readies, bresp/bvalid,
//                   rdata/rresp/rvalid.
//   master modport: the mirror image.
interface axi_lite_regfile_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 3
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/regfile_mem.sv
// NUM_REGS x DATA_WIDTH register storage.
//   clk_i, rst_ni            : clock, synchronous active-low clear of all words
//   we_i, waddr_i, wdata_i,
//   wstrb_i                  : byte-strobed write port, committed on the edge
//   re_i, rhit_i, raddr_i    : read enable; rhit_i=0 loads zero instead of a word
//   rdata_o                  : registered read data, held until the next re_i
module regfile_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  localparam int IDX_W     = $clog2(NUM_REGS),
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_W-1:0]     wstrb_i,
  input  logic                  re_i,
  input  logic                  rhit_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read samples mem_q before this edge's write lands, so a same-edge
  // read of the word being written returns the old contents.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_i[b]) begin
            mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
      if (re_i) begin
        rdata_q <= rhit_i ? mem_q[raddr_i] : '0;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI-Lite responder backed by a small word-addressed register file.
//   s_axi_aclk    : clock
//   s_axi_aresetn : synchronous active-low reset; clears memory, FSMs, outputs
//   s_axi         : AXI-Lite slave bundle (AW, W, B, AR, R channels)
// Word index is the byte address with the sub-word bits dropped. Indices at or
// beyond NUM_REGS get SLVERR: writes are dropped, reads return zero.
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RESP_WIDTH = DEF_RESP_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  axi_lite_regfile_slave_if.slave   s_axi
);

  localparam int ADDR_LSB   = word_lsb(DATA_WIDTH);
  localparam int IDX_FULL_W = ADDR_WIDTH - ADDR_LSB;
  localparam int IDX_W      = $clog2(NUM_REGS);
  localparam int STRB_W     = DATA_WIDTH / 8;

  // One extra bit so the compare still works when NUM_REGS fills the space.
  localparam logic [IDX_FULL_W:0] NUM_REGS_EXT = (IDX_FULL_W+1)'(NUM_REGS);
  localparam logic [RESP_WIDTH-1:0] OKAY_R   = RESP_WIDTH'(RESP_OKAY);
  localparam logic [RESP_WIDTH-1:0] SLVERR_R = RESP_WIDTH'(RESP_SLVERR);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr[ADDR_WIDTH-1:ADDR_LSB]} < NUM_REGS_EXT;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_LSB +: IDX_W];
  endfunction

  // ---------------- write path ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;

  logic                  aw_fire, w_fire;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_hit;
  logic                  mem_we;

  assign aw_fire = s_axi.awvalid & awready_q;
  assign w_fire  = s_axi.wvalid & wready_q;

  // A beat handshaking this cycle is used directly so AW and W arriving
  // together commit on the same edge.
  assign wr_addr = aw_fire ? s_axi.awaddr : awaddr_q;
  assign wr_data = w_fire  ? s_axi.wdata  : wdata_q;
  assign wr_strb = w_fire  ? s_axi.wstrb  : wstrb_q;
  assign wr_hit  = in_range(wr_addr);

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;

    case (wr_state_q)
      WR_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.awaddr;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
        end
        if (aw_held_d && w_held_d) begin
          mem_we     = wr_hit;
          bvalid_d   = 1'b1;
          bresp_d    = wr_hit ? OKAY_R : SLVERR_R;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.bready) begin
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    awready_d = (wr_state_d == WR_IDLE) && !aw_held_d;
    wready_d  = (wr_state_d == WR_IDLE) && !w_held_d;
  end

  // ---------------- read path ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic                  rvalid_q, rvalid_d;
  logic [RESP_WIDTH-1:0] rresp_q, rresp_d;
  logic                  arready_q, arready_d;
  logic                  ar_fire;
  logic                  rd_hit;
  logic                  mem_re;

  assign ar_fire = s_axi.arvalid & arready_q;
  assign rd_hit  = in_range(s_axi.araddr);

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    mem_re     = 1'b0;

    case (rd_state_q)
      RD_IDLE: begin
        if (ar_fire) begin
          mem_re     = 1'b1;
          rvalid_d   = 1'b1;
          rresp_d    = rd_hit ? OKAY_R : SLVERR_R;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    arready_d = (rd_state_d == RD_IDLE);
  end

  // ---------------- state registers ----------------
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      arready_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      rd_state_q <= rd_state_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      arready_q  <= arready_d;
    end
  end

  regfile_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_mem (
    .clk_i   (s_axi_aclk),
    .rst_ni  (s_axi_aresetn),
    .we_i    (mem_we),
    .waddr_i (word_idx(wr_addr)),
    .wdata_i (wr_data),
    .wstrb_i (wr_strb),
    .re_i    (mem_re),
    .rhit_i  (rd_hit),
    .raddr_i (word_idx(s_axi.araddr)),
    .rdata_o (s_axi.rdata)
  );

  // Sub-word address bits carry no meaning for a word-addressed file.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{wr_addr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
`timescale 1ns/1ps
module tb_axi_lite_regfile_slave;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_regfile_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESP_WIDTH(3)) bus ();

  axi_lite_regfile_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .RESP_WIDTH (3),
    .NUM_REGS   (8)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rstn),
    .s_axi         (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_mem [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: 8 words of 4 bytes at byte addresses 0x00..0x1F.
  function automatic bit ref_hit(input logic [7:0] a);
    return (int'(a) / 4) < 8;
  endfunction

  function automatic logic [31:0] ref_resp(input logic [7:0] a);
    return ref_hit(a) ? 32'd0 : 32'd2;
  endfunction

  function automatic logic [31:0] ref_rdata(input logic [7:0] a);
    return ref_hit(a) ? ref_mem[int'(a) / 4] : 32'd0;
  endfunction

  task automatic ref_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    if (ref_hit(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) ref_mem[int'(a) / 4][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_fire, w_fire;
    int cyc = 0;
    logic [31:0] exp_resp;
    while (!(aw_done && w_done)) begin
      if (cyc > 40) begin
        chk("wr_handshake_timeout", 32'd0, 32'd1);
        break;
      end
      chk("awready_idle", 32'(bus.awready), 32'(!aw_done));
      chk("wready_idle", 32'(bus.wready), 32'(!w_done));
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.awaddr  = addr;
      bus.wvalid  = !w_done && (cyc >= w_dly);
      bus.wdata   = data;
      bus.wstrb   = strb;
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      tick();
      aw_done |= aw_fire;
      w_done  |= w_fire;
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    exp_resp = ref_resp(addr);
    ref_write(addr, data, strb);
    chk("bvalid_latency", 32'(bus.bvalid), 32'd1);
    chk("bresp", 32'(bus.bresp), exp_resp);
    chk("awready_in_resp", 32'(bus.awready), 32'd0);
    chk("wready_in_resp", 32'(bus.wready), 32'd0);
    for (int i = 0; i < b_dly; i++) begin
      bus.bready = 1'b0;
      tick();
      chk("bvalid_hold", 32'(bus.bvalid), 32'd1);
      chk("bresp_hold", 32'(bus.bresp), exp_resp);
      chk("awready_hold", 32'(bus.awready), 32'd0);
      chk("wready_hold", 32'(bus.wready), 32'd0);
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("bvalid_clear", 32'(bus.bvalid), 32'd0);
    chk("awready_back", 32'(bus.awready), 32'd1);
    chk("wready_back", 32'(bus.wready), 32'd1);
  endtask

  task automatic axi_read(input logic [7:0] addr, input int r_dly);
    logic [31:0] exp_d, exp_r;
    exp_d = ref_rdata(addr);
    exp_r = ref_resp(addr);
    chk("arready_idle", 32'(bus.arready), 32'd1);
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    tick();
    bus.arvalid = 1'b0;
    chk("rvalid_latency", 32'(bus.rvalid), 32'd1);
    chk("rdata", bus.rdata, exp_d);
    chk("rresp", 32'(bus.rresp), exp_r);
    chk("arready_busy", 32'(bus.arready), 32'd0);
    for (int i = 0; i < r_dly; i++) begin
      bus.rready = 1'b0;
      tick();
      chk("rvalid_hold", 32'(bus.rvalid), 32'd1);
      chk("rdata_hold", bus.rdata, exp_d);
      chk("rresp_hold", 32'(bus.rresp), exp_r);
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("rvalid_clear", 32'(bus.rvalid), 32'd0);
    chk("arready_back", 32'(bus.arready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_w;
    logic [7:0]  ra;
    bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
    ref_clear();

    // Reset: everything reads zero, including the readies.
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rstn = 1'b1;
    tick();
    chk("post_rst_awready", 32'(bus.awready), 32'd1);
    chk("post_rst_wready", 32'(bus.wready), 32'd1);
    chk("post_rst_arready", 32'(bus.arready), 32'd1);
    chk("post_rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("post_rst_rvalid", 32'(bus.rvalid), 32'd0);

    axi_read(8'h08, 0);

    // AW and W together.
    axi_write(8'h04, 32'h0000_0017, 4'hF, 0, 0, 0);
    axi_read(8'h04, 0);
    chk("tp_word1", ref_mem[1], 32'h17);

    // W leads AW by 3 cycles, partial strobes.
    axi_write(8'h10, 32'hAABB_CCDD, 4'h5, 3, 0, 0);
    axi_read(8'h10, 0);
    chk("tp_word4", ref_mem[4], 32'h00BB_00DD);

    // AW leads W; stalled response and stalled read data.
    axi_write(8'h08, 32'h1234_5678, 4'hF, 0, 2, 5);
    axi_read(8'h08, 4);

    // Out of range.
    axi_write(8'h20, 32'hDEAD_BEEF, 4'hF, 0, 1, 0);
    axi_read(8'h3C, 0);
    axi_read(8'h20, 1);
    axi_read(8'h00, 0);

    // Zero strobe, and low address bits ignored.
    axi_write(8'h0C, 32'hFFFF_FFFF, 4'h0, 1, 0, 0);
    axi_read(8'h0E, 0);
    axi_write(8'h1F, 32'h8765_4321, 4'hA, 0, 0, 1);
    axi_read(8'h1C, 0);

    // Same-edge read and write to one word: read sees the old value.
    old_w = ref_mem[1];
    bus.awvalid = 1; bus.awaddr = 8'h04;
    bus.wvalid = 1; bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF;
    bus.arvalid = 1; bus.araddr = 8'h04;
    tick();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    ref_write(8'h04, 32'h5555_AAAA, 4'hF);
    chk("same_edge_rdata_old", bus.rdata, old_w);
    chk("same_edge_bvalid", 32'(bus.bvalid), 32'd1);
    chk("same_edge_rvalid", 32'(bus.rvalid), 32'd1);
    bus.bready = 1; bus.rready = 1;
    tick();
    bus.bready = 0; bus.rready = 0;
    chk("same_edge_bvalid_clear", 32'(bus.bvalid), 32'd0);
    chk("same_edge_rvalid_clear", 32'(bus.rvalid), 32'd0);
    axi_read(8'h04, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      ra = 8'($urandom_range(0, 47));
      if ($urandom_range(0, 1) == 0) begin
        axi_write(ra, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        axi_read(ra, $urandom_range(0, 2));
      end
    end

    // Reset while a response is pending.
    bus.awvalid = 1; bus.awaddr = 8'h18;
    bus.wvalid = 1; bus.wdata = 32'h9999_9999; bus.wstrb = 4'hF;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    chk("pre_rst_bvalid", 32'(bus.bvalid), 32'd1);
    rstn = 1'b0;
    tick();
    chk("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("mid_rst_awready", 32'(bus.awready), 32'd0);
    rstn = 1'b1;
    tick();
    ref_clear();
    chk("after_rst_bvalid", 32'(bus.bvalid), 32'd0);
    tick();
    chk("after_rst_no_stale_b", 32'(bus.bvalid), 32'd0);

    // A lone W latched before reset must be discarded.
    bus.wvalid = 1; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
    tick();
    bus.wvalid = 0;
    chk("w_held_wready", 32'(bus.wready), 32'd0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("w_discard_wready", 32'(bus.wready), 32'd1);
    bus.awvalid = 1; bus.awaddr = 8'h00;
    tick();
    bus.awvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("no_resp_without_w", 32'(bus.bvalid), 32'd0);
      tick();
    end
    bus.wvalid = 1; bus.wdata = 32'h0000_0011; bus.wstrb = 4'hF;
    tick();
    bus.wvalid = 0;
    ref_write(8'h00, 32'h0000_0011, 4'hF);
    chk("late_w_bvalid", 32'(bus.bvalid), 32'd1);
    bus.bready = 1;
    tick();
    bus.bready = 0;
    for (int i = 0; i < 8; i++) axi_read(8'(4 * i), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
